voice_mixer: RTL and testbench
==============================

Name: voice_mixer

Overview:
Parametrised successor to the fixed divide-by-8 output sum in synth. Mixes NUM_VOICES signed voice samples into one output sample, with per-voice gain, per-voice mute and saturation. The sum is computed sequentially, one voice per clock, using one multiply-accumulate, and is started by a sample strobe. Sits between the voice instances and the output stage (PWM/DAC) and shares the synth register-write bus.

Parameters:
NUM_VOICES, 8, voice count (1..63); voices numbered 1..NUM_VOICES.
SAMPLE_WIDTH, 24, signed width of voice and output samples.
GAIN_WIDTH, 16, unsigned gain width (2..24); 2^(GAIN_WIDTH-1) = unity.
REG_VALUE_WIDTH, 24, register data width.

Ports:
i_Clock  in  1  sole clock.
i_Reset  in  1  synchronous, active-high reset.
i_SampleStrobe  in  1  one-cycle pulse that starts a mix frame.
i_VoiceSamples  in  NUM_VOICES*SAMPLE_WIDTH  packed signed samples; voice v occupies slice [(v-1)*SAMPLE_WIDTH +: SAMPLE_WIDTH].
i_RegisterNumber  in  12  register address.
i_RegisterValue  in  REG_VALUE_WIDTH  write data.
i_RegisterWriteEnable  in  1  write strobe.
i_RegisterReadEnable  in  1  read strobe.
o_RegisterReadData  out  REG_VALUE_WIDTH  read data, registered.
o_Sample  out  SAMPLE_WIDTH  signed mixed sample, held until the next frame.
o_SampleValid  out  1  one-cycle pulse when o_Sample updates.
o_Busy  out  1  high while a frame is in progress.

Behaviour:
- Register map:
  - 12'h000: MUTE mask; bit v-1 mutes voice v. Read/write.
  - 12'h001: STATUS; bit0 OVERRUN, bit1 CLIP; both sticky. Writing 1 to a bit clears it.
  - {v[5:0], 6'h07}: GAIN for voice v, from i_RegisterValue[GAIN_WIDTH-1:0]. Read/write.
  - Writes to any other address, or for v > NUM_VOICES, are ignored.
- Read port:
  - o_RegisterReadData updates 1 cycle after i_RegisterReadEnable and holds between reads.
  - Data is zero-extended; unmapped addresses read 0.
- Reset values:
  - All gains = 2^(GAIN_WIDTH-1); MUTE = 0; STATUS = 0.
  - o_Sample = 0, o_SampleValid = 0, o_Busy = 0, o_RegisterReadData = 0; FSM in IDLE.
- FSM states: IDLE, ACCUM, SCALE, OUTPUT.
- IDLE:
  - On i_SampleStrobe: snapshot all samples, gains and MUTE; clear acc; idx = 1; enter ACCUM.
  - o_Busy goes high in the next cycle.
- ACCUM:
  - Each cycle: acc += muted[idx] ? 0 : sample[idx] * gain[idx], as a signed*unsigned product.
  - Product width SAMPLE_WIDTH+GAIN_WIDTH+1; acc adds clog2(NUM_VOICES) guard bits, so no overflow is possible.
  - After idx = NUM_VOICES, enter SCALE.
- SCALE:
  - Arithmetic shift right by GAIN_WIDTH-1 (floor toward -inf).
  - Saturate to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1]; if saturation occurred, set CLIP.
- OUTPUT: load o_Sample, pulse o_SampleValid, drop o_Busy, return to IDLE.
- Latency: strobe in cycle 0 gives o_SampleValid in cycle NUM_VOICES+2 (cycle 10 at default NUM_VOICES).
  - Minimum strobe spacing is NUM_VOICES+3 cycles.
  - A strobe in the OUTPUT cycle counts as busy.
- Boundary conditions:
  - Strobe while not in IDLE: ignored, OVERRUN set, current frame unaffected.
  - Register writes during a frame take effect from the next frame, because the frame uses the snapshot.
  - Status clear and set in the same cycle: set wins.
  - Reset mid-frame: aborts the frame; all outputs return to reset values the next cycle; no valid pulse.
  - NUM_VOICES = 1 must work; the idx counter wraps nowhere.

Decomposition:
- Package voice_mixer_pkg holds:
  - register address constants (MIX_REG_MUTE, MIX_REG_STATUS, MIX_REG_GAIN_OFFSET = 6'h07);
  - the FSM state enum;
  - a saturate function.
- One natural sub-module: mixer_mac, the registered signed*unsigned multiply-accumulate with clear/enable.

Test Plan:
- Reset, all gains unity, every voice = 1000, strobe → o_Sample = 8000, valid exactly 10 cycles after strobe, o_Busy high for cycles 1-9 and low again in cycle 10, CLIP = 0.
- Every voice = 24'h7FFFFF → o_Sample = 24'h7FFFFF, CLIP = 1. Every voice = 24'h800000 → o_Sample = 24'h800000. Write 2 to STATUS → CLIP reads 0.
- Gain[1] = 16'h4000, other voices muted: voice1 = 1001 → 500; voice1 = -1001 → -501 (floor).
- MUTE = 8'hFE, voices = 1..8 → o_Sample = 1. Read 12'h000 → 24'h0000FE one cycle after read enable. Read 12'h3C7 → 0.
- Strobe at cycle 0 and again at cycle 4 → one valid pulse only (cycle 10), OVERRUN = 1. Gain write at cycle 3 does not change that frame's result.
- Assert reset at cycle 5 of a frame → no valid pulse, o_Sample = 0, o_Busy = 0, gains read back unity.

Source files
------------

// File: rtl/voice_mixer_pkg.sv
// Shared definitions for the voice mixer: register map, FSM states, saturation.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package voice_mixer_pkg;

  localparam int          REG_ADDR_WIDTH      = 12;
  localparam logic [11:0] MIX_REG_MUTE        = 12'h000;
  localparam logic [11:0] MIX_REG_STATUS      = 12'h001;
  localparam logic [5:0]  MIX_REG_GAIN_OFFSET = 6'h07;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCALE,
    OUTPUT
  } mix_state_t;

  // Clamp a signed value into the range of a signed 'width'-bit number.
  // Callers compare the result with the input to detect clipping.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/voice_mixer_if.sv
// Bundles the mixer's sample path and register bus into one connection.
// Latency: n/a (wiring only).
// Backpressure: none; strobes arriving while the mixer is busy are dropped by the mixer.
// Ports: i_SampleStrobe/i_VoiceSamples in, register write/read bus in,
//        o_RegisterReadData, o_Sample, o_SampleValid, o_Busy out.
interface voice_mixer_if #(
  parameter int NUM_VOICES      = 8,
  parameter int SAMPLE_WIDTH    = 24,
  parameter int REG_VALUE_WIDTH = 24
) ();
  import voice_mixer_pkg::*;

  logic                               i_SampleStrobe;
  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] i_VoiceSamples;
  logic [REG_ADDR_WIDTH-1:0]          i_RegisterNumber;
  logic [REG_VALUE_WIDTH-1:0]         i_RegisterValue;
  logic                               i_RegisterWriteEnable;
  logic                               i_RegisterReadEnable;
  logic [REG_VALUE_WIDTH-1:0]         o_RegisterReadData;
  logic [SAMPLE_WIDTH-1:0]            o_Sample;
  logic                               o_SampleValid;
  logic                               o_Busy;

  modport master (
    output i_SampleStrobe, i_VoiceSamples, i_RegisterNumber, i_RegisterValue,
           i_RegisterWriteEnable, i_RegisterReadEnable,
    input  o_RegisterReadData, o_Sample, o_SampleValid, o_Busy
  );

  modport slave (
    input  i_SampleStrobe, i_VoiceSamples, i_RegisterNumber, i_RegisterValue,
           i_RegisterWriteEnable, i_RegisterReadEnable,
    output o_RegisterReadData, o_Sample, o_SampleValid, o_Busy
  );
endinterface

// File: rtl/voice_mixer_mac.sv
// Signed sample times unsigned gain, accumulated into a guarded register.
// Latency: 1 cycle from i_Enable to o_Acc update; i_Clear wins over i_Enable.
// Backpressure: none; accumulates every enabled cycle.
// Ports: i_Clock, i_Reset, i_Clear, i_Enable, i_Sample (signed), i_Gain (unsigned), o_Acc.
module mixer_mac #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int GAIN_WIDTH   = 16,
  parameter int ACC_WIDTH    = 44
) (
  input  logic                           i_Clock,
  input  logic                           i_Reset,
  input  logic                           i_Clear,
  input  logic                           i_Enable,
  input  logic signed [SAMPLE_WIDTH-1:0] i_Sample,
  input  logic [GAIN_WIDTH-1:0]          i_Gain,
  output logic signed [ACC_WIDTH-1:0]    o_Acc
);
  localparam int PROD_WIDTH = SAMPLE_WIDTH + GAIN_WIDTH + 1;

  logic signed [PROD_WIDTH-1:0] samp_ext;
  logic signed [PROD_WIDTH-1:0] gain_ext;
  logic signed [PROD_WIDTH-1:0] product;

  // Gain is zero-extended so the multiply treats it as unsigned.
  assign samp_ext = {{(PROD_WIDTH-SAMPLE_WIDTH){i_Sample[SAMPLE_WIDTH-1]}}, i_Sample};
  assign gain_ext = {{(PROD_WIDTH-GAIN_WIDTH){1'b0}}, i_Gain};
  assign product  = samp_ext * gain_ext;

  always_ff @(posedge i_Clock) begin
    if (i_Reset || i_Clear) begin
      o_Acc <= '0;
    end else if (i_Enable) begin
      o_Acc <= o_Acc + ACC_WIDTH'(product);
    end
  end
endmodule

// File: rtl/voice_mixer.sv
// Mixes NUM_VOICES signed samples with per-voice gain/mute into one saturated sample.
// Latency: strobe in cycle 0 -> o_SampleValid in cycle NUM_VOICES+2; one voice per clock.
// Backpressure: none; strobes while busy (including the output cycle) are dropped and flag OVERRUN.
// Ports: i_Clock, i_Reset (sync, active high), bus (voice_mixer_if.slave: samples, strobe,
//        register bus, o_Sample, o_SampleValid, o_Busy, o_RegisterReadData).
module voice_mixer
  import voice_mixer_pkg::*;
#(
  parameter int NUM_VOICES      = 8,
  parameter int SAMPLE_WIDTH    = 24,
  parameter int GAIN_WIDTH      = 16,
  parameter int REG_VALUE_WIDTH = 24
) (
  input logic          i_Clock,
  input logic          i_Reset,
  voice_mixer_if.slave bus
);
  localparam int GUARD_BITS = $clog2(NUM_VOICES);
  localparam int ACC_WIDTH  = SAMPLE_WIDTH + GAIN_WIDTH + 1 + GUARD_BITS;
  localparam int SEL_WIDTH  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [SEL_WIDTH-1:0]  LAST_SEL     = SEL_WIDTH'(NUM_VOICES - 1);
  localparam logic [5:0]            NUM_VOICES_6 = 6'(NUM_VOICES);
  localparam logic [GAIN_WIDTH-1:0] GAIN_UNITY   = {1'b1, {(GAIN_WIDTH-1){1'b0}}};

  mix_state_t state_q, state_d;

  // Live register file.
  logic [GAIN_WIDTH-1:0] gain_q [NUM_VOICES];
  logic [NUM_VOICES-1:0] mute_q;
  logic                  overrun_q, clip_q;
  logic [REG_VALUE_WIDTH-1:0] rd_d, rd_q;

  // Frame snapshot, so register writes mid-frame only affect the next frame.
  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] samp_snap;
  logic [GAIN_WIDTH-1:0]              gain_snap [NUM_VOICES];
  logic [NUM_VOICES-1:0]              mute_snap;

  logic [SEL_WIDTH-1:0]           voice_sel;
  logic                           start, mac_en, load_out, busy, valid;
  logic signed [SAMPLE_WIDTH-1:0] mac_sample, out_q;
  logic [GAIN_WIDTH-1:0]          mac_gain;
  logic signed [ACC_WIDTH-1:0]    acc, acc_scaled;
  logic signed [63:0]             acc_wide, acc_sat;
  logic                           clipped;

  logic [5:0] reg_voice, gain_sel;
  logic       gain_hit, gain_wr, mute_wr, status_wr, overrun_set, clip_set;

  // Register decode: gain registers live at {voice, 6'h07} for voices 1..NUM_VOICES.
  assign reg_voice = bus.i_RegisterNumber[11:6];
  assign gain_sel  = reg_voice - 6'd1;
  assign gain_hit  = (bus.i_RegisterNumber[5:0] == MIX_REG_GAIN_OFFSET) &&
                     (reg_voice != 6'd0) && (reg_voice <= NUM_VOICES_6);
  assign gain_wr   = bus.i_RegisterWriteEnable && gain_hit;
  assign mute_wr   = bus.i_RegisterWriteEnable && (bus.i_RegisterNumber == MIX_REG_MUTE);
  assign status_wr = bus.i_RegisterWriteEnable && (bus.i_RegisterNumber == MIX_REG_STATUS);

  assign overrun_set = bus.i_SampleStrobe && (state_q != IDLE);
  assign clip_set    = load_out && clipped;

  always_comb begin
    rd_d = '0;
    if (bus.i_RegisterNumber == MIX_REG_MUTE) begin
      rd_d = REG_VALUE_WIDTH'(mute_q);
    end else if (bus.i_RegisterNumber == MIX_REG_STATUS) begin
      rd_d = REG_VALUE_WIDTH'({clip_q, overrun_q});
    end else if (gain_hit) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (gain_sel == 6'(v)) rd_d = REG_VALUE_WIDTH'(gain_q[v]);
      end
    end
  end

  // Status bits are sticky; a set in the same cycle as a write-1-to-clear wins.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      for (int v = 0; v < NUM_VOICES; v++) gain_q[v] <= GAIN_UNITY;
      mute_q    <= '0;
      overrun_q <= 1'b0;
      clip_q    <= 1'b0;
      rd_q      <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (gain_wr && (gain_sel == 6'(v))) gain_q[v] <= GAIN_WIDTH'(bus.i_RegisterValue);
      end
      if (mute_wr) mute_q <= NUM_VOICES'(bus.i_RegisterValue);
      overrun_q <= overrun_set || (overrun_q && !(status_wr && bus.i_RegisterValue[0]));
      clip_q    <= clip_set    || (clip_q    && !(status_wr && bus.i_RegisterValue[1]));
      if (bus.i_RegisterReadEnable) rd_q <= rd_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (start) begin
      samp_snap <= bus.i_VoiceSamples;
      gain_snap <= gain_q;
      mute_snap <= mute_q;
    end
  end

  // Current voice operands; a muted voice contributes through a zero gain.
  always_comb begin
    mac_sample = '0;
    mac_gain   = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (voice_sel == SEL_WIDTH'(v)) begin
        mac_sample = samp_snap[v*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        mac_gain   = mute_snap[v] ? '0 : gain_snap[v];
      end
    end
  end

  mixer_mac #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .GAIN_WIDTH   (GAIN_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH)
  ) u_mac (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Clear  (start),
    .i_Enable (mac_en),
    .i_Sample (mac_sample),
    .i_Gain   (mac_gain),
    .o_Acc    (acc)
  );

  // Arithmetic shift floors toward -inf; unity gain is 2^(GAIN_WIDTH-1).
  assign acc_scaled = acc >>> (GAIN_WIDTH - 1);
  assign acc_wide   = 64'(acc_scaled);
  assign acc_sat    = saturate(acc_wide, SAMPLE_WIDTH);
  assign clipped    = (acc_sat != acc_wide);

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    mac_en   = 1'b0;
    load_out = 1'b0;
    busy     = 1'b0;
    valid    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_SampleStrobe) begin
          start   = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        busy   = 1'b1;
        mac_en = 1'b1;
        if (voice_sel == LAST_SEL) state_d = SCALE;
      end
      SCALE: begin
        busy     = 1'b1;
        load_out = 1'b1;
        state_d  = OUTPUT;
      end
      OUTPUT: begin
        valid   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      voice_sel <= '0;
      out_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        voice_sel <= '0;
      end else if (mac_en && (voice_sel != LAST_SEL)) begin
        voice_sel <= voice_sel + SEL_WIDTH'(1);
      end
      if (load_out) out_q <= SAMPLE_WIDTH'(acc_sat);
    end
  end

  assign bus.o_Sample           = out_q;
  assign bus.o_SampleValid      = valid;
  assign bus.o_Busy             = busy;
  assign bus.o_RegisterReadData = rd_q;
endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer with a scoreboard of expected mixed samples.
// Expected values come from a behavioural model of the mix over the bench's own register shadow.
module tb_voice_mixer;
  localparam int NV = 8;
  localparam int SW = 24;
  localparam int GW = 16;
  localparam int RW = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  voice_mixer_if #(.NUM_VOICES(NV), .SAMPLE_WIDTH(SW), .REG_VALUE_WIDTH(RW)) vif ();

  voice_mixer #(
    .NUM_VOICES(NV), .SAMPLE_WIDTH(SW), .GAIN_WIDTH(GW), .REG_VALUE_WIDTH(RW)
  ) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (vif)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [SW-1:0] sb [$];
  int tb_samp [NV];
  int tb_gain [NV];
  logic [NV-1:0] tb_mute;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_samples();
    for (int v = 0; v < NV; v++) vif.i_VoiceSamples[v*SW +: SW] = SW'(tb_samp[v]);
  endtask

  task automatic set_all(input int val);
    for (int v = 0; v < NV; v++) tb_samp[v] = val;
    drive_samples();
  endtask

  task automatic reg_write(input logic [11:0] addr, input logic [RW-1:0] val);
    vif.i_RegisterNumber      = addr;
    vif.i_RegisterValue       = val;
    vif.i_RegisterWriteEnable = 1'b1;
    tick();
    vif.i_RegisterWriteEnable = 1'b0;
  endtask

  task automatic set_gain(input int v, input int g);
    reg_write({6'(v), 6'h07}, RW'(g));
    tb_gain[v-1] = g;
  endtask

  task automatic set_mute(input logic [NV-1:0] m);
    reg_write(12'h000, RW'(m));
    tb_mute = m;
  endtask

  task automatic reg_check(input string tag, input logic [11:0] addr, input logic [RW-1:0] exp);
    vif.i_RegisterNumber     = addr;
    vif.i_RegisterReadEnable = 1'b1;
    tick();
    vif.i_RegisterReadEnable = 1'b0;
    check(tag, 32'(vif.o_RegisterReadData), 32'(exp));
  endtask

  // Reference mix: sum of unmuted sample*gain, floor-shift by GW-1, clamp to SW bits.
  function automatic logic [SW-1:0] model_mix();
    longint acc;
    acc = 0;
    for (int v = 0; v < NV; v++) begin
      if (!tb_mute[v]) acc += longint'(tb_samp[v]) * longint'(tb_gain[v]);
    end
    acc = acc >>> (GW - 1);
    if (acc > 64'sd8388607) acc = 64'sd8388607;
    else if (acc < -64'sd8388608) acc = -64'sd8388608;
    return acc[SW-1:0];
  endfunction

  // One frame: strobe now (cycle 0), observe cycles 1..14. Optional events at cycle k:
  // second strobe, gain[1]=0 write, STATUS OVERRUN clear, reset pulse (0 = none).
  task automatic run_frame(input string tag, input bit chk_busy, input int strobe2_k,
                           input int gain_k, input int clr_k, input int rst_k);
    int seen_k;
    int pulses;
    seen_k = -1;
    pulses = 0;
    sb.push_back(model_mix());
    vif.i_SampleStrobe = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      vif.i_SampleStrobe        = 1'b0;
      vif.i_RegisterWriteEnable = 1'b0;
      rst                       = 1'b0;
      if (chk_busy && k <= 10) check({tag, " busy"}, 32'(vif.o_Busy), 32'(k <= 9));
      if (rst_k != 0 && k == rst_k + 1) begin
        check({tag, " sample after reset"}, 32'(vif.o_Sample), 32'h0);
        check({tag, " busy after reset"}, 32'(vif.o_Busy), 32'h0);
        check({tag, " rdata after reset"}, 32'(vif.o_RegisterReadData), 32'h0);
      end
      if (vif.o_SampleValid) begin
        pulses++;
        if (seen_k < 0) seen_k = k;
        if (sb.size() != 0) check({tag, " sample"}, 32'(vif.o_Sample), 32'(sb.pop_front()));
        else check({tag, " pending"}, 32'(sb.size()), 32'd1);
      end
      if (k == strobe2_k) vif.i_SampleStrobe = 1'b1;
      if (k == gain_k) begin
        vif.i_RegisterNumber      = {6'd1, 6'h07};
        vif.i_RegisterValue       = '0;
        vif.i_RegisterWriteEnable = 1'b1;
        tb_gain[0]                = 0;
      end
      if (k == clr_k) begin
        vif.i_RegisterNumber      = 12'h001;
        vif.i_RegisterValue       = RW'(1);
        vif.i_RegisterWriteEnable = 1'b1;
      end
      if (k == rst_k) rst = 1'b1;
    end
    if (rst_k == 0) begin
      check({tag, " latency"}, 32'(seen_k), 32'd10);
      check({tag, " pulses"}, 32'(pulses), 32'd1);
    end else begin
      check({tag, " pulses"}, 32'(pulses), 32'd0);
      check({tag, " pending"}, 32'(sb.size()), 32'd1);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vif.i_SampleStrobe        = 1'b0;
    vif.i_VoiceSamples        = '0;
    vif.i_RegisterNumber      = '0;
    vif.i_RegisterValue       = '0;
    vif.i_RegisterWriteEnable = 1'b0;
    vif.i_RegisterReadEnable  = 1'b0;
    for (int v = 0; v < NV; v++) begin
      tb_gain[v] = 32768;
      tb_samp[v] = 0;
    end
    tb_mute = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst sample", 32'(vif.o_Sample), 32'h0);
    check("rst valid", 32'(vif.o_SampleValid), 32'h0);
    check("rst busy", 32'(vif.o_Busy), 32'h0);
    check("rst rdata", 32'(vif.o_RegisterReadData), 32'h0);
    reg_check("rst status", 12'h001, 24'h0);
    reg_check("rst gain1", 12'h047, 24'h008000);
    reg_check("rst mute", 12'h000, 24'h0);

    // Unity gain, all voices 1000
    set_all(1000);
    run_frame("unity", 1'b1, 0, 0, 0, 0);
    reg_check("unity status", 12'h001, 24'h0);

    // Saturation both ways, CLIP set then cleared
    set_all(8388607);
    run_frame("pos sat", 1'b0, 0, 0, 0, 0);
    reg_check("clip set", 12'h001, 24'h2);
    set_all(-8388608);
    run_frame("neg sat", 1'b0, 0, 0, 0, 0);
    reg_write(12'h001, 24'h2);
    reg_check("clip cleared", 12'h001, 24'h0);

    // Half gain on voice 1 alone, floor rounding
    set_gain(1, 16'h4000);
    set_mute(8'hFE);
    set_all(0);
    tb_samp[0] = 1001;
    drive_samples();
    run_frame("half pos", 1'b0, 0, 0, 0, 0);
    tb_samp[0] = -1001;
    drive_samples();
    run_frame("half neg", 1'b0, 0, 0, 0, 0);

    // Mute mask, readback and unmapped reads
    set_gain(1, 32768);
    for (int v = 0; v < NV; v++) tb_samp[v] = v + 1;
    drive_samples();
    run_frame("mute", 1'b0, 0, 0, 0, 0);
    reg_check("mute read", 12'h000, 24'h0000FE);
    tick();
    check("mute read hold", 32'(vif.o_RegisterReadData), 32'h0000FE);
    reg_write(12'h3C7, 24'h1234);
    reg_check("voice15 gain", 12'h3C7, 24'h0);
    reg_check("unmapped", 12'h002, 24'h0);
    reg_check("gain8", 12'h207, 24'h008000);

    // Overrun and snapshot isolation
    set_mute(8'h00);
    set_all(1000);
    run_frame("overrun", 1'b1, 4, 3, 0, 0);
    reg_check("overrun set", 12'h001, 24'h1);
    run_frame("new gain", 1'b0, 5, 0, 5, 0);
    reg_check("set wins", 12'h001, 24'h1);
    reg_write(12'h001, 24'h1);
    reg_check("overrun cleared", 12'h001, 24'h0);

    // Reset mid-frame
    run_frame("abort", 1'b0, 0, 0, 0, 5);
    for (int v = 0; v < NV; v++) tb_gain[v] = 32768;
    tb_mute = '0;
    reg_check("abort gain1", 12'h047, 24'h008000);
    reg_check("abort status", 12'h001, 24'h0);
    run_frame("recover", 1'b1, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
